// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch front-end:
// FSM encoding, queue entry layout and the PC increment helper.
package inst_fetcher_pkg;

    localparam int IFQ_DEPTH_BIT = 2;
    localparam int IF_STATE_BIT  = 2;
    localparam int ADDR_W        = 32;
    localparam int INST_W        = 32;

    typedef enum logic [IF_STATE_BIT-1:0] {
        IF_IDLE  = 2'd0,
        IF_WAIT  = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular FIFO of {addr, inst} entries between the fetch FSM and the decoder.
// Clear wins over push and pop; storage itself is not reset.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int DEPTH_BIT = IFQ_DEPTH_BIT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 clear_i,
    input  ifq_entry_t           push_data_i,
    output ifq_entry_t           head_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [DEPTH_BIT:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_BIT;

    ifq_entry_t             mem_q [DEPTH];
    logic [DEPTH_BIT-1:0]   head_q, head_d;
    logic [DEPTH_BIT-1:0]   tail_q, tail_d;
    logic [DEPTH_BIT:0]     count_q, count_d;
    logic                   do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = count_q[DEPTH_BIT];
    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

    always_comb begin
        do_push = push_i && !full_o && !clear_i;
        do_pop  = pop_i && !empty_o && !clear_i;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[tail_q] <= push_data_i;
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one outstanding icache read at a time, returned words
// queued for the decoder, with redirect/flush driven by the decoder's if_clear.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          QUEUE_DEPTH_BIT = IFQ_DEPTH_BIT,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_inst,
    output logic        valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic        dec_accept,
    input  logic        if_clear,
    input  logic [31:0] if_set_addr
);

    localparam logic [QUEUE_DEPTH_BIT:0] QDEPTH = {1'b1, {QUEUE_DEPTH_BIT{1'b0}}};

    if_state_e                state_q, state_d;
    logic [31:0]              pc_q, pc_d;
    logic                     req_valid_q, req_valid_d;
    logic [31:0]              req_addr_q, req_addr_d;
    logic                     req_fire, fetch_push;
    logic                     q_push, q_pop, q_clear;
    logic                     q_empty, q_full;
    logic [QUEUE_DEPTH_BIT:0] q_count;
    ifq_entry_t               q_head, q_wdata;

    assign icache_req_valid = req_valid_q;
    assign icache_req_addr  = req_addr_q;
    assign valid            = !q_empty;
    assign inst_addr        = q_head.addr;
    assign inst             = q_head.inst;
    assign req_fire         = req_valid_q && icache_req_ready;
    assign q_wdata          = {pc_q, icache_resp_inst};

    // Queue strobes are gated by rdy_in so a stalled pipeline freezes the FIFO too.
    assign q_push  = rdy_in && fetch_push && !if_clear && !q_full;
    assign q_pop   = rdy_in && valid && dec_accept && !if_clear;
    assign q_clear = rdy_in && if_clear;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        fetch_push  = 1'b0;

        case (state_q)
            IF_IDLE: begin
                if (req_fire) begin
                    req_valid_d = 1'b0;
                    state_d     = IF_WAIT;
                end else if (q_count < QDEPTH) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = pc_q;
                end
            end
            IF_WAIT: begin
                if (icache_resp_valid) begin
                    fetch_push = 1'b1;
                    pc_d       = next_pc(pc_q);
                    state_d    = IF_IDLE;
                end
            end
            IF_FLUSH: begin
                if (icache_resp_valid) state_d = IF_IDLE;
            end
            default: state_d = IF_IDLE;
        endcase

        // Redirect overrides everything; an accepted-but-unanswered fetch must be drained in FLUSH.
        if (if_clear) begin
            fetch_push = 1'b0;
            pc_d       = if_set_addr;
            case (state_q)
                IF_IDLE: begin
                    if (req_fire) begin
                        req_valid_d = 1'b0;
                        state_d     = IF_FLUSH;
                    end else begin
                        req_valid_d = 1'b1;
                        req_addr_d  = if_set_addr;
                    end
                end
                IF_WAIT, IF_FLUSH: begin
                    state_d = icache_resp_valid ? IF_IDLE : IF_FLUSH;
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    inst_queue #(
        .DEPTH_BIT (QUEUE_DEPTH_BIT)
    ) u_queue (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push_i      (q_push),
        .pop_i       (q_pop),
        .clear_i     (q_clear),
        .push_data_i (q_wdata),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .full_o      (q_full),
        .count_o     (q_count)
    );

endmodule
